// File: rtl/counter_ctrl.sv
// Programmable interval timer: prescaled WIDTH-bit up-counter with period compare,
// one-shot / auto-reload modes, and a start/pause/stop/load command interface.
module counter_ctrl #(
    parameter int unsigned       WIDTH      = 8,
    parameter int unsigned       PRESCALE   = 1,
    parameter logic [WIDTH-1:0]  PERIOD_RST = '1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] period_in,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] period_q;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             mode_q;
    logic             tick_q;
    logic             done_q;
    logic             en;
    logic             terminal;
    logic             cmdStart;
    logic             cmdLoad;

    // Strict command priority: a higher-priority command masks the lower ones.
    assign cmdStart = start & ~pause;
    assign cmdLoad  = load & ~pause & ~start;

    assign en       = (presc_q == PRESC_MAX);
    assign presc_d  = en ? '0 : presc_q + PW'(1);
    assign terminal = (count_q == period_q);
    assign count_d  = terminal ? '0 : count_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= PERIOD_RST;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                count_q <= '0;
                presc_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (cmdStart) begin
                            state_q <= RUN;
                            count_q <= '0;
                            presc_q <= '0;
                            mode_q  <= mode;
                        end else if (cmdLoad) begin
                            period_q <= period_in;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_q <= PAUSE;
                        end else begin
                            presc_q <= presc_d;
                            if (en) begin
                                count_q <= count_d;
                                if (terminal) begin
                                    tick_q <= 1'b1;
                                    if (!mode_q) begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (cmdStart) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Programmable interval-timer controller that owns and sequences a WIDTH-bit up-counter on behalf of the rest of the design. Accepts start/pause/stop/load commands, applies a clock prescaler, compares the count against a programmed period, and emits a one-cycle tick at each terminal count. Supports one-shot and auto-reload modes, and reports its state so software-style sequencers and other blocks can schedule around it.

## Interface
- WIDTH, 8, counter and period width in bits
- PRESCALE, 1, clk cycles per count enable (≥1); 1 = count every cycle
- PERIOD_RST, all ones, reset value of the period register
- clk  input  1  rising-edge clock
- res  input  1  reset, synchronous, active-low: acts only on a rising clk edge while res=0
- start  input  1  start from IDLE/DONE, resume from PAUSE (level, sampled each edge)
- pause  input  1  RUN→PAUSE
- stop  input  1  abort to IDLE from any state
- load  input  1  period_reg <= period_in (IDLE/DONE only)
- mode  input  1  sampled on start from IDLE/DONE: 0 one-shot, 1 auto-reload
- period_in  input  WIDTH  new period value
- count  output  WIDTH  current counter value (registered)
- tick  output  1  one-cycle pulse at every terminal count
- done  output  1  one-cycle pulse on one-shot completion
- busy  output  1  high in RUN or PAUSE
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset (res=0 at an edge): state=IDLE, count=0, period_reg=PERIOD_RST, mode_reg=0, prescaler=0, tick=0, done=0, busy=0. Reset wins over every command, in any state.
- Command priority within a cycle: stop > pause > start > load.
- IDLE: count held at 0. load updates period_reg. start → RUN; count=0, prescaler=0, mode_reg<=mode.
- RUN: prescaler counts 0..PRESCALE-1; en=1 when prescaler==PRESCALE-1 (always 1 if PRESCALE=1). On en:
  - count≠period_reg: count<=count+1.
  - count==period_reg (terminal): count<=0, tick<=1 for one cycle; mode_reg=1 → stay RUN; mode_reg=0 → DONE, done<=1 for one cycle.
- RUN + pause → PAUSE: count and prescaler frozen, no tick generated.
- PAUSE + start → RUN: counting resumes from the frozen count and prescaler; mode_reg is not re-sampled.
- stop in any state → IDLE, count=0, prescaler=0. tick/done are not asserted by stop.
- DONE: count=0, period_reg retained. load allowed. start restarts exactly as from IDLE.
- load in RUN/PAUSE is ignored; period_reg does not change.
- Period 0: count stays 0; tick fires on every en.
- Arithmetic: count is unsigned WIDTH-bit. Terminal compare guarantees count never exceeds period_reg, so no natural wrap occurs; period 2^WIDTH-1 runs the full range 0..255 and then returns to 0.
- busy = (state==RUN || state==PAUSE), decoded from registered state.

## Timing
- All outputs are registered, so they change only on rising clk edges.
- start sampled at edge N → state=RUN after edge N. With PRESCALE=1, count=1 after edge N+1.
- Tick interval = (period_reg+1)·PRESCALE cycles. tick is high in the cycle following the terminal en edge, concurrent with count=0.
- One-shot: done, tick and state=DONE all become visible after the same edge.
- pause at edge M: count after edge M equals count before edge M (no increment at M).
- stop and start together at the same edge → IDLE.
- Reset during RUN: the next edge with res=0 forces all reset values, including dropping any pending tick/done.

## Test plan
- Reset, then load=1 with period_in=3, then start with mode=1, PRESCALE=1 → count sequence 1,2,3,0,1,… ; tick high every 4th cycle aligned with count=0; busy=1; done never asserted.
- period 5, mode=0, start → count 1..5, then 0; one cycle with tick=1 and done=1; state=DONE, busy=0; a second start reruns the same sequence.
- PRESCALE=4, period 2, auto-reload → count increments every 4 cycles; tick every 12 cycles.
- Pause at count=2, hold 10 cycles, then start → count stays 2 for the whole pause, then resumes 3; no tick during the pause; load of 7 during the pause leaves the period at 2.
- stop+start in the same cycle, and stop during PAUSE → state=IDLE, count=0; period 0 in auto-reload → tick every cycle, count stays 0.
- res=0 for one edge mid-RUN at count=200, period 255 → count=0, state=IDLE, period_reg=255 (PERIOD_RST), tick=done=0. Then load 255 and run one-shot → count passes 255 and returns to 0, done=1.
